serdesphy_prbs_engine: RTL and testbench

SERDESPHY_PRBS_ENGINE -- requirements
Module: serdesphy_prbs_engine

---
 rtl/serdesphy_pkg.sv | 64 ++++++
 rtl/serdesphy_lfsr_step.sv | 29 ++
 rtl/serdesphy_prbs_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_serdesphy_prbs_engine.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// Shared encodings, polynomial constants and small helper functions for the
// PRBS generator/checker.
package serdesphy_pkg;

    typedef enum logic [1:0] {
        SEL_PRBS7  = 2'b00,
        SEL_PRBS15 = 2'b01,
        SEL_PRBS31 = 2'b10,
        SEL_RSVD   = 2'b11
    } prbs_sel_e;

    typedef enum logic [1:0] {
        CHK_IDLE   = 2'b00,
        CHK_SEED   = 2'b01,
        CHK_CHECK  = 2'b10,
        CHK_LOCKED = 2'b11
    } chk_state_e;

    // State register is sized for the longest polynomial; shorter ones only
    // look at their low bits.
    localparam int LFSR_W = 31;

    localparam int PRBS7_ORDER   = 7;
    localparam int PRBS7_TAP_HI  = 6;
    localparam int PRBS7_TAP_LO  = 5;
    localparam int PRBS15_ORDER  = 15;
    localparam int PRBS15_TAP_HI = 14;
    localparam int PRBS15_TAP_LO = 13;
    localparam int PRBS31_ORDER  = 31;
    localparam int PRBS31_TAP_HI = 30;
    localparam int PRBS31_TAP_LO = 27;

    function automatic int poly_order(logic [1:0] sel);
        case (sel)
            SEL_PRBS15: return PRBS15_ORDER;
            SEL_PRBS31: return PRBS31_ORDER;
            default:    return PRBS7_ORDER;
        endcase
    endfunction

    // Fibonacci feedback: XOR of the two tap bits; reserved code acts as PRBS7.
    function automatic logic feedback_bit(logic [LFSR_W-1:0] st, logic [1:0] sel);
        case (sel)
            SEL_PRBS15: return st[PRBS15_TAP_HI] ^ st[PRBS15_TAP_LO];
            SEL_PRBS31: return st[PRBS31_TAP_HI] ^ st[PRBS31_TAP_LO];
            default:    return st[PRBS7_TAP_HI] ^ st[PRBS7_TAP_LO];
        endcase
    endfunction

    // Number of words needed to fill the checker LFSR: ceil(order / data_w).
    function automatic logic [4:0] seed_words(logic [1:0] sel, int data_w);
        return 5'((poly_order(sel) + data_w - 1) / data_w);
    endfunction

    function automatic logic [4:0] popcount16(logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/serdesphy_lfsr_step.sv
// Combinational advance of the PRBS LFSR by DATA_W bits. The first bit
// produced lands in the MSB of the output word.
module serdesphy_lfsr_step
    import serdesphy_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [LFSR_W-1:0] state_in,
    input  logic [1:0]        sel,
    output logic [LFSR_W-1:0] state_out,
    output logic [DATA_W-1:0] word_out
);

    // Shift DATA_W feedback bits in, collecting each as an output bit.
    always_comb begin
        logic [LFSR_W-1:0] st_v;
        logic              nb_v;
        st_v     = state_in;
        nb_v     = 1'b0;
        word_out = '0;
        for (int i = 0; i < DATA_W; i++) begin
            nb_v                  = feedback_bit(st_v, sel);
            st_v                  = {st_v[LFSR_W-2:0], nb_v};
            word_out[DATA_W-1-i]  = nb_v;
        end
        state_out = st_v;
    end

endmodule

// File: rtl/serdesphy_prbs_engine.sv
// PRBS7/15/31 pattern generator plus self-synchronising checker with lock
// tracking and a saturating bit-error counter.
module serdesphy_prbs_engine
    import serdesphy_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int ERR_CNT_W  = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                 clk_ref_24m,
    input  logic                 rst_n,
    input  logic [1:0]           prbs_sel,
    input  logic                 gen_en,
    output logic [DATA_W-1:0]    gen_data,
    output logic                 gen_valid,
    input  logic                 chk_en,
    input  logic [DATA_W-1:0]    chk_data,
    input  logic                 chk_valid,
    input  logic                 err_clr,
    output logic                 prbs_lock,
    output logic                 prbs_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           chk_state
);

    localparam int RUN_W = 16;
    localparam int SUM_W = ERR_CNT_W + 6;

    logic [1:0]           sel_r;
    logic                 sel_chg_s;
    logic [LFSR_W-1:0]    gen_lfsr_r;
    logic [LFSR_W-1:0]    gen_seed_s;
    logic [LFSR_W-1:0]    gen_next_s;
    logic [DATA_W-1:0]    gen_word_s;
    logic [DATA_W-1:0]    gen_data_r;
    logic                 gen_valid_r;

    chk_state_e           state_r;
    chk_state_e           state_nxt_s;
    logic [LFSR_W-1:0]    chk_lfsr_r;
    logic [LFSR_W-1:0]    chk_lfsr_nxt_s;
    logic [LFSR_W-1:0]    chk_next_s;
    logic [DATA_W-1:0]    chk_word_s;
    logic [4:0]           seed_cnt_r;
    logic [4:0]           seed_cnt_nxt_s;
    logic [RUN_W-1:0]     good_run_r;
    logic [RUN_W-1:0]     good_run_nxt_s;
    logic [RUN_W-1:0]     bad_run_r;
    logic [RUN_W-1:0]     bad_run_nxt_s;
    logic [4:0]           pop_s;
    logic [4:0]           err_add_s;
    logic                 err_pulse_s;
    logic                 prbs_lock_r;
    logic                 prbs_err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [SUM_W-1:0]     sum_s;

    assign sel_chg_s  = (prbs_sel != sel_r);
    // A polynomial change restarts the generator from all-ones immediately.
    assign gen_seed_s = sel_chg_s ? {LFSR_W{1'b1}} : gen_lfsr_r;
    assign pop_s      = popcount16(16'(chk_data ^ chk_word_s));
    assign sum_s      = SUM_W'(err_cnt_r) + SUM_W'(err_add_s);

    serdesphy_lfsr_step #(.DATA_W(DATA_W)) u_gen_step (
        .state_in  (gen_seed_s),
        .sel       (prbs_sel),
        .state_out (gen_next_s),
        .word_out  (gen_word_s)
    );

    serdesphy_lfsr_step #(.DATA_W(DATA_W)) u_chk_step (
        .state_in  (chk_lfsr_r),
        .sel       (prbs_sel),
        .state_out (chk_next_s),
        .word_out  (chk_word_s)
    );

    // Remember the previous polynomial select to detect changes.
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= 2'b00;
        end else begin
            sel_r <= prbs_sel;
        end
    end

    // Generator: one word per enabled cycle, reseed on polynomial change.
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            gen_lfsr_r  <= {LFSR_W{1'b1}};
            gen_data_r  <= '0;
            gen_valid_r <= 1'b0;
        end else if (gen_en) begin
            gen_lfsr_r  <= gen_next_s;
            gen_data_r  <= gen_word_s;
            gen_valid_r <= 1'b1;
        end else begin
            gen_lfsr_r  <= gen_seed_s;
            gen_valid_r <= 1'b0;
        end
    end

    // Checker next-state: seed from received data, then predict and compare.
    always_comb begin
        state_nxt_s    = state_r;
        chk_lfsr_nxt_s = chk_lfsr_r;
        seed_cnt_nxt_s = seed_cnt_r;
        good_run_nxt_s = good_run_r;
        bad_run_nxt_s  = bad_run_r;
        err_add_s      = 5'd0;
        err_pulse_s    = 1'b0;
        if (!chk_en || sel_chg_s) begin
            state_nxt_s    = chk_en ? CHK_SEED : CHK_IDLE;
            seed_cnt_nxt_s = 5'd0;
            good_run_nxt_s = '0;
            bad_run_nxt_s  = '0;
        end else if (!chk_valid) begin
            state_nxt_s = (state_r == CHK_IDLE) ? CHK_SEED : state_r;
        end else begin
            case (state_r)
                CHK_IDLE: begin
                    state_nxt_s    = CHK_SEED;
                    seed_cnt_nxt_s = 5'd0;
                    good_run_nxt_s = '0;
                    bad_run_nxt_s  = '0;
                end
                CHK_SEED: begin
                    chk_lfsr_nxt_s = LFSR_W'({chk_lfsr_r, chk_data});
                    if (seed_cnt_r + 5'd1 == seed_words(prbs_sel, DATA_W)) begin
                        state_nxt_s    = CHK_CHECK;
                        seed_cnt_nxt_s = 5'd0;
                        good_run_nxt_s = '0;
                    end else begin
                        seed_cnt_nxt_s = seed_cnt_r + 5'd1;
                    end
                end
                CHK_CHECK: begin
                    chk_lfsr_nxt_s = chk_next_s;
                    if (chk_data != chk_word_s) begin
                        state_nxt_s    = CHK_SEED;
                        seed_cnt_nxt_s = 5'd0;
                        good_run_nxt_s = '0;
                    end else if (good_run_r + 16'd1 == RUN_W'(LOCK_CNT)) begin
                        state_nxt_s    = CHK_LOCKED;
                        good_run_nxt_s = '0;
                        bad_run_nxt_s  = '0;
                    end else begin
                        good_run_nxt_s = good_run_r + 16'd1;
                    end
                end
                CHK_LOCKED: begin
                    chk_lfsr_nxt_s = chk_next_s;
                    err_add_s      = pop_s;
                    if (pop_s != 5'd0) begin
                        err_pulse_s = 1'b1;
                        if (bad_run_r + 16'd1 == RUN_W'(UNLOCK_CNT)) begin
                            state_nxt_s    = CHK_SEED;
                            seed_cnt_nxt_s = 5'd0;
                            bad_run_nxt_s  = '0;
                        end else begin
                            bad_run_nxt_s = bad_run_r + 16'd1;
                        end
                    end else begin
                        bad_run_nxt_s = '0;
                    end
                end
                default: begin
                    state_nxt_s = CHK_IDLE;
                end
            endcase
        end
    end

    // Checker state, run counters and registered lock/error flags.
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= CHK_IDLE;
            chk_lfsr_r  <= {LFSR_W{1'b1}};
            seed_cnt_r  <= 5'd0;
            good_run_r  <= '0;
            bad_run_r   <= '0;
            prbs_lock_r <= 1'b0;
            prbs_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            chk_lfsr_r  <= chk_lfsr_nxt_s;
            seed_cnt_r  <= seed_cnt_nxt_s;
            good_run_r  <= good_run_nxt_s;
            bad_run_r   <= bad_run_nxt_s;
            prbs_lock_r <= (state_nxt_s == CHK_LOCKED);
            prbs_err_r  <= err_pulse_s;
        end
    end

    // Saturating bit-error accumulator; clear has priority over increment.
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_cnt_r <= '0;
        end else if (err_add_s != 5'd0) begin
            if (sum_s[SUM_W-1:ERR_CNT_W] != '0) begin
                err_cnt_r <= '1;
            end else begin
                err_cnt_r <= sum_s[ERR_CNT_W-1:0];
            end
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign gen_data  = gen_data_r;
    assign gen_valid = gen_valid_r;
    assign prbs_lock = prbs_lock_r;
    assign prbs_err  = prbs_err_r;
    assign err_cnt   = err_cnt_r;
    assign chk_state = state_r;

endmodule

// File: tb/tb_serdesphy_prbs_engine.sv
// Directed bench: loopback generator->checker, lock timing, error injection,
// counter saturation, polynomial switch and asynchronous reset.
module tb_serdesphy_prbs_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  prbs_sel;
    logic        gen_en;
    logic        chk_en;
    logic        err_clr1;
    logic        err_clr2;
    logic [3:0]  flip1;
    logic [3:0]  flip2;

    logic [3:0]  gen_data1, gen_data2, chk_data1, chk_data2;
    logic        gen_valid1, gen_valid2;
    logic        lock1, lock2, perr1, perr2;
    logic [15:0] err_cnt1;
    logic [3:0]  err_cnt2;
    logic [1:0]  state1, state2;

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;

    assign chk_data1 = gen_data1 ^ flip1;
    assign chk_data2 = gen_data2 ^ flip2;

    always #20 clk = ~clk;

    serdesphy_prbs_engine u_dut1 (
        .clk_ref_24m (clk),        .rst_n     (rst_n),
        .prbs_sel    (prbs_sel),   .gen_en    (gen_en),
        .gen_data    (gen_data1),  .gen_valid (gen_valid1),
        .chk_en      (chk_en),     .chk_data  (chk_data1),
        .chk_valid   (gen_valid1), .err_clr   (err_clr1),
        .prbs_lock   (lock1),      .prbs_err  (perr1),
        .err_cnt     (err_cnt1),   .chk_state (state1)
    );

    serdesphy_prbs_engine #(.ERR_CNT_W(4), .UNLOCK_CNT(1000)) u_dut2 (
        .clk_ref_24m (clk),        .rst_n     (rst_n),
        .prbs_sel    (prbs_sel),   .gen_en    (gen_en),
        .gen_data    (gen_data2),  .gen_valid (gen_valid2),
        .chk_en      (chk_en),     .chk_data  (chk_data2),
        .chk_valid   (gen_valid2), .err_clr   (err_clr2),
        .prbs_lock   (lock2),      .prbs_err  (perr2),
        .err_cnt     (err_cnt2),   .chk_state (state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_words [5];
        exp_words[0] = 4'h0; exp_words[1] = 4'h2; exp_words[2] = 4'h0;
        exp_words[3] = 4'hC; exp_words[4] = 4'h2;

        rst_n = 1'b0; prbs_sel = 2'b00; gen_en = 1'b0; chk_en = 1'b0;
        err_clr1 = 1'b0; err_clr2 = 1'b0; flip1 = 4'h0; flip2 = 4'h0;
        #5;
        check("rst_gen_data",  32'(gen_data1),  32'h0);
        check("rst_gen_valid", 32'(gen_valid1), 32'h0);
        check("rst_lock",      32'(lock1),      32'h0);
        check("rst_err",       32'(perr1),      32'h0);
        check("rst_err_cnt",   32'(err_cnt1),   32'h0);
        check("rst_state",     32'(state1),     32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("gen_valid_idle", 32'(gen_valid1), 32'h0);

        // PRBS7 sequence from all-ones seed, loopback into the checker.
        gen_en = 1'b1; chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("prbs7_word", 32'(gen_data1), 32'(exp_words[i]));
            check("prbs7_valid", 32'(gen_valid1), 32'h1);
        end
        repeat (5) tick();
        check("prbs7_lock_early", 32'(lock1), 32'h0);
        tick();
        check("prbs7_lock", 32'(lock1), 32'h1);
        check("prbs7_state", 32'(state1), 32'h3);
        check("prbs7_lock_dut2", 32'(lock2), 32'h1);

        // Long clean run.
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (perr1) err_pulses++;
        end
        check("clean_err_pulses", 32'(err_pulses), 32'h0);
        check("clean_err_cnt", 32'(err_cnt1), 32'h0);
        check("clean_lock", 32'(lock1), 32'h1);

        // Single bit flip in one word.
        flip1 = 4'b0001;
        tick();
        flip1 = 4'h0;
        check("flip1_pulse", 32'(perr1), 32'h1);
        check("flip1_cnt", 32'(err_cnt1), 32'h1);
        check("flip1_lock", 32'(lock1), 32'h1);
        tick();
        check("flip1_pulse_end", 32'(perr1), 32'h0);
        check("flip1_lock_hold", 32'(lock1), 32'h1);

        // Four consecutive corrupted words -> drop lock, reseed, relock.
        flip1 = 4'hF;
        repeat (3) tick();
        check("burst_lock_hold", 32'(lock1), 32'h1);
        tick();
        flip1 = 4'h0;
        check("burst_unlock", 32'(lock1), 32'h0);
        check("burst_state_seed", 32'(state1), 32'h1);
        check("burst_err_cnt", 32'(err_cnt1), 32'd17);
        repeat (9) tick();
        check("relock_early", 32'(lock1), 32'h0);
        tick();
        check("relock", 32'(lock1), 32'h1);

        // Saturation on the 4-bit counter, then clear coincident with errors.
        flip2 = 4'hF;
        tick(); check("sat_4", 32'(err_cnt2), 32'h4);
        tick(); check("sat_8", 32'(err_cnt2), 32'h8);
        tick(); check("sat_12", 32'(err_cnt2), 32'hC);
        tick(); check("sat_15", 32'(err_cnt2), 32'hF);
        tick(); check("sat_hold", 32'(err_cnt2), 32'hF);
        check("sat_lock", 32'(lock2), 32'h1);
        err_clr2 = 1'b1;
        tick(); check("clr_with_err", 32'(err_cnt2), 32'h0);
        err_clr2 = 1'b0; flip2 = 4'h0;
        tick(); check("clr_after", 32'(err_cnt2), 32'h0);

        // PRBS15: stop, switch, restart and time the lock.
        gen_en = 1'b0; chk_en = 1'b0; prbs_sel = 2'b01;
        tick();
        check("idle_state", 32'(state1), 32'h0);
        check("idle_gen_valid", 32'(gen_valid1), 32'h0);
        tick();
        check("idle_err_hold", 32'(err_cnt1), 32'd17);
        gen_en = 1'b1; chk_en = 1'b1;
        repeat (12) tick();
        check("prbs15_lock_early", 32'(lock1), 32'h0);
        tick();
        check("prbs15_lock", 32'(lock1), 32'h1);

        // Mid-stream switch to PRBS31.
        prbs_sel = 2'b10;
        tick();
        check("sel_chg_state", 32'(state1), 32'h1);
        check("sel_chg_lock", 32'(lock1), 32'h0);
        check("sel_chg_word", 32'(gen_data1), 32'h0);
        repeat (15) tick();
        check("prbs31_lock_early", 32'(lock1), 32'h0);
        tick();
        check("prbs31_lock", 32'(lock1), 32'h1);

        // Asynchronous reset mid-cycle.
        #5 rst_n = 1'b0;
        #1;
        check("arst_gen_data", 32'(gen_data1), 32'h0);
        check("arst_gen_valid", 32'(gen_valid1), 32'h0);
        check("arst_lock", 32'(lock1), 32'h0);
        check("arst_err", 32'(perr1), 32'h0);
        check("arst_err_cnt", 32'(err_cnt1), 32'h0);
        check("arst_state", 32'(state1), 32'h0);
        #5 rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(gen_valid1), 32'h1);
        check("post_rst_word", 32'(gen_data1), 32'h0);
        repeat (15) tick();
        check("post_rst_lock_early", 32'(lock1), 32'h0);
        tick();
        check("post_rst_lock", 32'(lock1), 32'h1);
        check("post_rst_err_cnt", 32'(err_cnt1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
